// File: rtl/clk_tick_gen.sv
// clk_tick_gen: multi-channel programmable tick and square-wave divider with shadowed divisors
module clk_tick_gen #(
  parameter int NUM_CH = 2,
  parameter int CNT_W = 28,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {28'd249999999, 28'd24999999},
  localparam int SEL_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sync_clr,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_data,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq,
  output logic [NUM_CH-1:0] pending
);
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] cnt, active, shadow;
    logic t, s, p, hit, wrap, reload;
    assign hit = div_wr && div_sel == SEL_W'(g);
    assign wrap = en && cnt == active;
    assign reload = sync_clr || wrap;
    assign tick[g] = t;
    assign sq[g] = s;
    assign pending[g] = p;
    // count to the active divisor, reload it from the shadow only at a wrap or restart
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        cnt <= '0;
        active <= DIV_INIT[g*CNT_W +: CNT_W];
        shadow <= DIV_INIT[g*CNT_W +: CNT_W];
        t <= 1'b0;
        s <= 1'b0;
        p <= 1'b0;
      end else begin
        if (hit) shadow <= div_data;
        if (reload) active <= shadow;
        p <= reload ? hit : p | hit;
        t <= !sync_clr && wrap;
        s <= sync_clr ? 1'b0 : wrap ? ~s : s;
        cnt <= reload ? '0 : en ? cnt + 1'b1 : cnt;
      end
  end
endmodule

// File: tb/tb_clk_tick_gen.sv
// tb_clk_tick_gen: directed checks of tick, sq and pending timing for clk_tick_gen
module tb_clk_tick_gen;
  logic clk = 1'b0;
  logic rst, en, sync_clr, div_wr, wr1;
  logic [0:0] div_sel, sel1;
  logic [7:0] div_data, data1;
  logic [1:0] tick, sq, pending;
  logic [0:0] tick1, sq1, pend1;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  clk_tick_gen #(.NUM_CH(2), .CNT_W(8), .DIV_INIT({8'd4, 8'd2})) dut (
    .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr), .div_wr(div_wr),
    .div_sel(div_sel), .div_data(div_data), .tick(tick), .sq(sq), .pending(pending));

  clk_tick_gen #(.NUM_CH(1), .CNT_W(8), .DIV_INIT(8'd3)) dut1 (
    .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr), .div_wr(wr1),
    .div_sel(sel1), .div_data(data1), .tick(tick1), .sq(sq1), .pending(pend1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b1; sync_clr = 1'b0; div_wr = 1'b0; div_sel = '0; div_data = '0;
    wr1 = 1'b0; sel1 = '0; data1 = '0;
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    tests++;
    if (tick !== 2'b00 || sq !== 2'b00 || pending !== 2'b00) begin
      fails++;
      $display("FAIL reset_state got tick=%b sq=%b pend=%b want 00 00 00", tick, sq, pending);
    end
  endtask

  task automatic test_free_run();
    do_reset();
    for (int e = 1; e <= 10; e++) begin
      step();
      tests++;
      if (tick !== {e % 5 == 0, e % 3 == 0} || sq[0] !== ((e / 3) % 2 == 1) || pending !== 2'b00) begin
        fails++;
        $display("FAIL free_run edge %0d got tick=%b sq0=%b pend=%b want tick=%b sq0=%b pend=00",
                 e, tick, sq[0], pending, {e % 5 == 0, e % 3 == 0}, (e / 3) % 2 == 1);
      end
    end
  endtask

  task automatic test_shadow_write();
    do_reset();
    step();
    div_wr = 1'b1; div_sel = 1'd0; div_data = 8'd5;
    step();
    div_wr = 1'b0;
    tests++;
    if (pending[0] !== 1'b1 || tick[0] !== 1'b0) begin
      fails++;
      $display("FAIL write_pending got pend0=%b tick0=%b want 1 0", pending[0], tick[0]);
    end
    step();
    tests++;
    if (tick[0] !== 1'b1 || pending[0] !== 1'b0) begin
      fails++;
      $display("FAIL old_period_wrap got tick0=%b pend0=%b want 1 0", tick[0], pending[0]);
    end
    for (int e = 4; e <= 15; e++) begin
      step();
      tests++;
      if (tick[0] !== (e == 9 || e == 15)) begin
        fails++;
        $display("FAIL new_period edge %0d got tick0=%b want %b", e, tick[0], e == 9 || e == 15);
      end
    end
  endtask

  task automatic test_zero_divisor();
    do_reset();
    div_wr = 1'b1; div_sel = 1'd1; div_data = 8'd0;
    step();
    div_wr = 1'b0;
    for (int e = 2; e <= 9; e++) begin
      step();
      tests++;
      if (tick[1] !== (e >= 5) || (e >= 5 && sq[1] !== ((e - 4) % 2 == 1))) begin
        fails++;
        $display("FAIL zero_div edge %0d got tick1=%b sq1=%b want tick1=%b sq1=%b",
                 e, tick[1], sq[1], e >= 5, (e - 4) % 2 == 1);
      end
    end
  endtask

  task automatic test_enable_hold();
    do_reset();
    repeat (4) step();
    en = 1'b0;
    for (int e = 5; e <= 8; e++) begin
      step();
      tests++;
      if (tick !== 2'b00 || sq[0] !== 1'b1) begin
        fails++;
        $display("FAIL en_hold edge %0d got tick=%b sq0=%b want 00 1", e, tick, sq[0]);
      end
    end
    en = 1'b1;
    step();
    tests++;
    if (tick !== 2'b10) begin
      fails++;
      $display("FAIL reenable_first got tick=%b want 10", tick);
    end
    step();
    tests++;
    if (tick[0] !== 1'b1 || sq[0] !== 1'b0) begin
      fails++;
      $display("FAIL reenable_wrap got tick0=%b sq0=%b want 1 0", tick[0], sq[0]);
    end
  endtask

  task automatic test_sync_clr_write();
    do_reset();
    repeat (4) step();
    sync_clr = 1'b1; div_wr = 1'b1; div_sel = 1'd0; div_data = 8'd7;
    step();
    sync_clr = 1'b0; div_wr = 1'b0;
    tests++;
    if (tick !== 2'b00 || sq !== 2'b00 || pending !== 2'b01) begin
      fails++;
      $display("FAIL sync_clr got tick=%b sq=%b pend=%b want 00 00 01", tick, sq, pending);
    end
    for (int e = 6; e <= 16; e++) begin
      step();
      tests++;
      if (tick[0] !== (e == 8 || e == 16) || pending[0] !== (e < 8)) begin
        fails++;
        $display("FAIL clr_period edge %0d got tick0=%b pend0=%b want %b %b",
                 e, tick[0], pending[0], e == 8 || e == 16, e < 8);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    div_wr = 1'b1; div_sel = 1'd1; div_data = 8'd9;
    step();
    div_wr = 1'b0;
    repeat (2) step();
    tests++;
    if (tick[0] !== 1'b1 || sq[0] !== 1'b1 || pending[1] !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset got tick0=%b sq0=%b pend1=%b want 1 1 1", tick[0], sq[0], pending[1]);
    end
    #1 rst = 1'b0;
    #1;
    tests++;
    if (tick !== 2'b00 || sq !== 2'b00 || pending !== 2'b00) begin
      fails++;
      $display("FAIL async_reset got tick=%b sq=%b pend=%b want 00 00 00", tick, sq, pending);
    end
  endtask

  task automatic test_bad_sel();
    do_reset();
    step();
    wr1 = 1'b1; sel1 = 1'd1; data1 = 8'd0;
    step();
    wr1 = 1'b0;
    tests++;
    if (pend1 !== 1'b0) begin
      fails++;
      $display("FAIL bad_sel_pending got %b want 0", pend1);
    end
    for (int e = 3; e <= 9; e++) begin
      step();
      tests++;
      if (tick1 !== (e % 4 == 0)) begin
        fails++;
        $display("FAIL bad_sel_period edge %0d got tick=%b want %b", e, tick1, e % 4 == 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_shadow_write();
    test_zero_divisor();
    test_enable_hold();
    test_sync_clr_write();
    test_async_reset();
    test_bad_sel();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
